wb_arbiter: RTL
===============

# wb_arbiter

Two-master Wishbone arbiter and sequencer for the CPU core's single external bus. It sits between the instruction-fetch port (driven by the PC stage) and the data port (driven by the MEM stage) on one side, and the core-level Wishbone master interface on the other. It grants the bus to one requester at a time, runs one classic single-beat cycle per grant, and returns read data with an ack pulse. It also raises per-port stall requests for the control unit, aborts fetches on pipeline flush, and bounds every bus cycle with a timeout.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles spent in a bus cycle without `wb_ack_i`. Legal range is 2..255; the counter is 8 bits.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `flush_i` in 1: pipeline flush from the control unit.
- `if_req_i` in 1: fetch request, held high until `if_ack_o`.
- `if_addr_i` in 32: fetch address.
- `if_data_o` out 32: fetched instruction word.
- `if_ack_o` out 1: one-cycle completion pulse for the fetch port.
- `mem_req_i` in 1: data request, held high until `mem_ack_o`.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_sel_i` in 4: byte lane select.
- `mem_addr_i` in 32: data address.
- `mem_data_i` in 32: write data.
- `mem_data_o` out 32: read data.
- `mem_ack_o` out 1: one-cycle completion pulse for the data port.
- `stall_req_if_o` out 1: `if_req_i & ~if_ack_o`.
- `stall_req_mem_o` out 1: `mem_req_i & ~mem_ack_o`.
- `wb_cyc_o` out 1, `wb_stb_o` out 1: bus cycle and strobe; always equal.
- `wb_we_o` out 1: write enable.
- `wb_sel_o` out 4: byte select.
- `wb_addr_o` out 32: bus address.
- `wb_data_o` out 32: bus write data.
- `wb_data_i` in 32: bus read data.
- `wb_ack_i` in 1: slave acknowledge.
- `bus_err_o` out 1: one-cycle pulse when a bus cycle times out.

## Operation
- FSM states are IDLE, BUSY_IF, BUSY_MEM and DONE. The `last_grant` register resets to IF.
- **IDLE, granting:**
  - Only `mem_req_i` is high: go to BUSY_MEM.
  - Only `if_req_i` is high: go to BUSY_IF.
  - Both are high: grant the port that is not `last_grant`. After reset, MEM therefore wins the first tie.
  - On every grant, update `last_grant` and clear the timeout counter.
- **On entry to a BUSY state:** register `wb_cyc_o`/`wb_stb_o` = 1 together with the addr/we/sel/data of the granted port.
  - The IF port always drives `wb_we_o` = 0, `wb_sel_o` = 4'hF and `wb_data_o` = 0.
- **BUSY_x with `wb_ack_i` = 1:**
  - Drop cyc/stb.
  - Latch `wb_data_i` into `x_data_o`; for writes, latch anyway and the port ignores it.
  - Pulse `x_ack_o` and go to DONE.
- **BUSY_x without ack:** increment the counter. When it reaches `TIMEOUT`−1:
  - Drop cyc/stb and latch `x_data_o` = 0.
  - Pulse `x_ack_o` and `bus_err_o`, then go to DONE.
- **BUSY_IF with `flush_i` = 1:** abort.
  - Drop cyc/stb and go to IDLE.
  - No `if_ack_o` is issued and no data is latched.
  - `flush_i` has priority over a simultaneous `wb_ack_i` or timeout.
- **BUSY_MEM is never flushed.** The access is committed and always completes.
- **DONE:** lasts one cycle, during which the ack pulse is visible. It then always returns to IDLE; requests are ignored while in DONE. This gives the requester one cycle to drop or change its request.
- `wb_ack_i` is ignored in IDLE and DONE, which covers a late ack after a flush.
- `flush_i` in IDLE or DONE has no effect.
- `x_data_o` holds its value until the next completion on that port.

## Timing
- All outputs are registered except the two stall requests.
- Reset (`rst` = 0) drives every registered output to 0 immediately and forces state IDLE and `last_grant` = IF.
- Reset in the middle of a cycle drops cyc/stb at once; no ack is produced.
- Request handshake for a request sampled in IDLE at edge 0:
  - cyc/stb are high from edge 0.
  - If the ack is sampled at edge k, `x_ack_o` is high for the single cycle after edge k, and cyc/stb are low after edge k.
- Minimum spacing between two grants is 3 cycles: request → grant → ack → DONE → next grant.
- Under continuous contention, grants alternate MEM, IF, MEM, …
- A timeout asserts after exactly `TIMEOUT` cycles with cyc high.

## Test plan
- **IF read:** `if_req_i` with `if_addr_i` = 0x00000100; slave acks 2 cycles after stb with 0xDEADBEEF. Required: `wb_addr_o` = 0x100, `wb_sel_o` = F, `wb_we_o` = 0; a single `if_ack_o` pulse with `if_data_o` = 0xDEADBEEF; `stall_req_if_o` high until that pulse.
- **MEM write:** `mem_we_i` = 1, `mem_sel_i` = 4'b0011, addr 0x80000004, data 0x12345678; slave acks immediately. Required: the bus shows exactly those values; `mem_ack_o` pulses once; `bus_err_o` = 0.
- **Contention:** both requests held continuously from reset, slave always acks after 1 cycle. Required: grant order MEM, IF, MEM, IF.
- **Flush:** assert `flush_i` 2 cycles into a BUSY_IF wait, then `wb_ack_i` arrives 1 cycle later. Required: cyc drops after the flush edge, no `if_ack_o`, the late ack is ignored, state is IDLE.
- **Timeout:** `TIMEOUT` = 16, MEM read with the slave never acking. Required: cyc high for exactly 16 cycles, then `mem_ack_o` and `bus_err_o` pulse together with `mem_data_o` = 0.
- **Reset mid-cycle:** pull `rst` low during BUSY_MEM. Required: all outputs are 0 asynchronously; after release, a tied request grants MEM first.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: fetch and data ports share one single-beat bus,
// with alternating tie-break, fetch abort on flush and a bounded cycle timeout.
module wb_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        stall_req_if_o,
  output logic        stall_req_mem_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        last_mem, last_mem_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        cyc_nxt, we_nxt;
  logic [3:0]  sel_nxt;
  logic [31:0] addr_nxt, wdata_nxt, if_data_nxt, mem_data_nxt;
  logic        if_ack_nxt, mem_ack_nxt, bus_err_nxt;
  logic        grant_mem, grant_if, timeout;

  // On a tie the port that did not win last time is granted.
  assign grant_mem = mem_req_i & (~if_req_i | ~last_mem);
  assign grant_if  = if_req_i & ~grant_mem;
  assign timeout   = (cnt == TO_LAST);

  assign stall_req_if_o  = if_req_i & ~if_ack_o;
  assign stall_req_mem_o = mem_req_i & ~mem_ack_o;
  assign wb_stb_o        = wb_cyc_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_mem   <= 1'b0;
      cnt        <= 8'd0;
      wb_cyc_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= 4'h0;
      wb_addr_o  <= 32'h0;
      wb_data_o  <= 32'h0;
      if_data_o  <= 32'h0;
      mem_data_o <= 32'h0;
      if_ack_o   <= 1'b0;
      mem_ack_o  <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_mem   <= last_mem_nxt;
      cnt        <= cnt_nxt;
      wb_cyc_o   <= cyc_nxt;
      wb_we_o    <= we_nxt;
      wb_sel_o   <= sel_nxt;
      wb_addr_o  <= addr_nxt;
      wb_data_o  <= wdata_nxt;
      if_data_o  <= if_data_nxt;
      mem_data_o <= mem_data_nxt;
      if_ack_o   <= if_ack_nxt;
      mem_ack_o  <= mem_ack_nxt;
      bus_err_o  <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_mem)     state_nxt = BUSY_MEM;
        else if (grant_if) state_nxt = BUSY_IF;
      end
      BUSY_IF: begin
        if (flush_i)                  state_nxt = IDLE;
        else if (wb_ack_i || timeout) state_nxt = DONE;
      end
      BUSY_MEM: begin
        if (wb_ack_i || timeout) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered bus/port values for the next cycle; ack and error are pulses.
  always_comb begin
    last_mem_nxt = last_mem;
    cnt_nxt      = cnt;
    cyc_nxt      = wb_cyc_o;
    we_nxt       = wb_we_o;
    sel_nxt      = wb_sel_o;
    addr_nxt     = wb_addr_o;
    wdata_nxt    = wb_data_o;
    if_data_nxt  = if_data_o;
    mem_data_nxt = mem_data_o;
    if_ack_nxt   = 1'b0;
    mem_ack_nxt  = 1'b0;
    bus_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_mem) begin
          last_mem_nxt = 1'b1;
          cnt_nxt      = 8'd0;
          cyc_nxt      = 1'b1;
          we_nxt       = mem_we_i;
          sel_nxt      = mem_sel_i;
          addr_nxt     = mem_addr_i;
          wdata_nxt    = mem_data_i;
        end else if (grant_if) begin
          last_mem_nxt = 1'b0;
          cnt_nxt      = 8'd0;
          cyc_nxt      = 1'b1;
          we_nxt       = 1'b0;
          sel_nxt      = 4'hF;
          addr_nxt     = if_addr_i;
          wdata_nxt    = 32'h0;
        end
      end
      BUSY_IF: begin
        if (flush_i) begin
          cyc_nxt = 1'b0;
        end else if (wb_ack_i) begin
          cyc_nxt     = 1'b0;
          if_data_nxt = wb_data_i;
          if_ack_nxt  = 1'b1;
        end else if (timeout) begin
          cyc_nxt     = 1'b0;
          if_data_nxt = 32'h0;
          if_ack_nxt  = 1'b1;
          bus_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      BUSY_MEM: begin
        if (wb_ack_i) begin
          cyc_nxt      = 1'b0;
          mem_data_nxt = wb_data_i;
          mem_ack_nxt  = 1'b1;
        end else if (timeout) begin
          cyc_nxt      = 1'b0;
          mem_data_nxt = 32'h0;
          mem_ack_nxt  = 1'b1;
          bus_err_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

endmodule
